strobe_divider_bank: RTL

//  Bank of NCH independent programmable clock-enable (strobe) generators.

---
 rtl/clkdiv_pkg.sv | 9 +
 rtl/strobe_div_chan.sv | 53 +++++
 rtl/strobe_divider_bank.sv | 34 +++
 3 files changed

// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared defaults and divisor helpers for the strobe divider bank
package clkdiv_pkg;
  localparam int CW_DEF = 16;
  localparam int DIV_DEF = 1500;
  typedef logic [CW_DEF-1:0] div_t;
  function automatic logic [31:0] clamp_div(input logic [31:0] d);
    return (d == 32'd0) ? 32'd1 : d;
  endfunction
endpackage

// File: rtl/strobe_div_chan.sv
// strobe_div_chan: one programmable tick/square-wave divider with glitch-free divisor update
module strobe_div_chan
  import clkdiv_pkg::*;
#(
  parameter int CW          = CW_DEF,
  parameter int DEFAULT_DIV = DIV_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  input  logic          wr,
  input  logic [CW-1:0] wdata,
  output logic          pend,
  output logic          tick,
  output logic          sq
);
  logic [CW-1:0] cnt_q, cnt_d, act_q, act_d, nxt_q, nxt_d, wval;
  logic          pend_q, pend_d, tick_q, tick_d, sq_q, sq_d, wrap, wr_idle;
  assign wval    = CW'(clamp_div(32'(wdata)));
  assign wrap    = en && (cnt_q == act_q - CW'(1));
  assign wr_idle = wr && !en && !clr;
  assign pend    = pend_q;
  assign tick    = tick_q;
  assign sq      = sq_q;
  // next state: clear restarts in phase, idle writes apply at once, busy writes wait for the wrap
  always_comb begin
    cnt_d  = (clr || wrap || (wr_idle && cnt_q >= wval)) ? '0 : en ? cnt_q + CW'(1) : cnt_q;
    tick_d = !clr && wrap;
    sq_d   = !clr && (sq_q ^ wrap);
    act_d  = wr_idle ? wval : ((clr || wrap) && pend_q) ? nxt_q : act_q;
    nxt_d  = wr ? wval : nxt_q;
    pend_d = wr ? (clr || en) : (clr || wrap) ? 1'b0 : pend_q;
  end
  // channel state flops, all outputs come straight from here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      act_q  <= CW'(DEFAULT_DIV);
      nxt_q  <= CW'(DEFAULT_DIV);
      pend_q <= 1'b0;
      tick_q <= 1'b0;
      sq_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      nxt_q  <= nxt_d;
      pend_q <= pend_d;
      tick_q <= tick_d;
      sq_q   <= sq_d;
    end
  end
endmodule

// File: rtl/strobe_divider_bank.sv
// strobe_divider_bank: NCH independent clock-enable strobe generators with runtime divisors
module strobe_divider_bank
  import clkdiv_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int CW          = CW_DEF,
  parameter int DEFAULT_DIV = DIV_DEF,
  localparam int SW         = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] en,
  input  logic           sync_clr,
  input  logic           div_wr,
  input  logic [SW-1:0]  div_sel,
  input  logic [CW-1:0]  div_data,
  output logic [NCH-1:0] pend,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] sq
);
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    strobe_div_chan #(.CW(CW), .DEFAULT_DIV(DEFAULT_DIV)) u_ch (
      .clk  (clk),
      .rst  (rst),
      .en   (en[i]),
      .clr  (sync_clr),
      .wr   (div_wr && (div_sel == SW'(i))),
      .wdata(div_data),
      .pend (pend[i]),
      .tick (tick[i]),
      .sq   (sq[i])
    );
  end
endmodule
